tick_stretcher: RTL
===================

Name: tick_stretcher

Overview:
Inverse companion of the level-to-tick edge detector: converts single-cycle `tick` pulses back into a clean level waveform. Each accepted tick produces a high pulse of exactly HIGH_CYCLES clocks, followed by a guaranteed low gap of LOW_CYCLES clocks. Used to drive slow consumers (LEDs, strobes, handshake lines) from tick sources. Ticks that cannot be honoured are counted, not silently lost.

Parameters:
HIGH_CYCLES, 4, length of the `level` high pulse in clocks; legal range 1..2**CNT_W.
LOW_CYCLES, 2, minimum `level` low gap after each pulse in clocks; legal range 0..2**CNT_W.
CNT_W, 8, width of the internal duration counter and of `drop_count`.
RETRIGGER, 0, 1 = a tick during HIGH restarts the pulse; 0 = a tick during HIGH is dropped.

Ports:
clock  in  1  single system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
tick  in  1  single-cycle request pulse; sampled every clock.
level  out  1  stretched output level, registered.
busy  out  1  high whenever state is not IDLE, registered.
overrun  out  1  one-cycle pulse in the cycle after a tick is dropped.
drop_count  out  CNT_W  count of dropped ticks; saturates at all-ones.

Behaviour:
- Reset priority: reset overrides a `tick` in the same cycle.
- State after reset:
  - state = IDLE, cnt = 0, pending = 0.
  - level = 0, busy = 0, overrun = 0, drop_count = 0.
  - Reset mid-pulse drops level on the next edge, and the in-progress pulse is not counted as dropped.
- States: IDLE, HIGH, GAP. All outputs are registered; none depends combinationally on `tick`.
- IDLE:
  - tick = 1 at edge N: state <= HIGH, cnt <= HIGH_CYCLES-1, level <= 1.
  - Level is therefore high from cycle N+1 (latency 1).
- HIGH, in priority order:
  - tick = 1 and RETRIGGER = 1: cnt <= HIGH_CYCLES-1 and stay in HIGH. This takes priority over expiry, so level stays high for HIGH_CYCLES cycles after the last tick.
  - tick = 1 and RETRIGGER = 0: tick is dropped (see drop rules); the pulse continues unaffected.
  - cnt == 0 and LOW_CYCLES > 0: state <= GAP, cnt <= LOW_CYCLES-1, level <= 0.
  - cnt == 0 and LOW_CYCLES == 0: state <= IDLE, level <= 0. A tick arriving in that same expiry cycle with RETRIGGER = 0 is dropped.
  - otherwise: cnt <= cnt-1.
- GAP (level = 0, busy = 1):
  - First tick in GAP: pending <= 1.
  - Tick while pending = 1: dropped.
  - cnt == 0 with (pending = 1 or tick = 1): state <= HIGH, cnt <= HIGH_CYCLES-1, level <= 1, pending <= 0. The new pulse is back-to-back with the gap, so the gap is exactly LOW_CYCLES.
  - cnt == 0 with no request: state <= IDLE.
  - otherwise: cnt <= cnt-1.
- Pulse width: the high time is exactly HIGH_CYCLES clocks. Level never glitches inside a pulse or a gap.
- busy: busy <= 1 on any transition into HIGH or GAP; busy <= 0 on entering IDLE.
- Drop rules:
  - overrun <= 1 for exactly one cycle per dropped tick; otherwise 0.
  - drop_count increments by 1 per drop and holds at 2**CNT_W-1.
  - A drop never alters cnt, state or level.
- Width rules:
  - cnt is CNT_W bits; the reload values HIGH_CYCLES-1 and LOW_CYCLES-1 are truncated to CNT_W.
  - No wrap-around is possible within the legal parameter ranges.

Test Plan:
- Defaults (HIGH_CYCLES=4, LOW_CYCLES=2, RETRIGGER=0); single tick at cycle 10 -> level=1 cycles 11-14, level=0 from 15; busy=1 cycles 11-16, busy=0 at 17; drop_count=0.
- Defaults; ticks at cycles 10 and 12 -> second tick dropped; overrun=1 at cycle 13 only; drop_count=1; level high 11-14 only.
- Defaults; ticks at 10, 15, 16 -> tick 15 goes pending; tick 16 is dropped (drop_count=1); second pulse high 17-20 after a low gap at 15-16.
- RETRIGGER=1; ticks at 10, 13, 16 -> level high continuously cycles 11-20; drop_count=0; overrun never asserted.
- LOW_CYCLES=0, CNT_W=2; 5 ticks all during HIGH pulses -> drop_count saturates at 3; level pulses remain exactly 4 cycles each.
- Defaults; tick at 10, reset asserted at 12 together with a tick -> level=0 and busy=0 at 13; drop_count=0; no pulse starts until a tick after reset deasserts.

Source files
------------

// File: rtl/tick_stretcher.sv
// ---------------------------------------------------------------------------
// tick_stretcher
//
// Turns single-cycle tick requests into a clean level waveform. Each accepted
// tick produces a HIGH_CYCLES-long high pulse on `level`, followed by a low
// gap of at least LOW_CYCLES clocks. Ticks that cannot be honoured are
// counted in a saturating drop counter and flagged on `overrun`.
//
// Ports
//   clock       in   rising-edge system clock
//   reset       in   synchronous, active-high reset (wins over tick)
//   tick        in   single-cycle request pulse
//   level       out  stretched output level (registered)
//   busy        out  high whenever the FSM is not idle (registered)
//   overrun     out  one-cycle pulse in the cycle after a tick is dropped
//   drop_count  out  saturating count of dropped ticks
//
// States
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | level low, waiting for a tick
//   HIGH    | level high, cnt counts down the remaining high cycles
//   GAP     | level low, cnt counts down the enforced low gap; one tick may
//           | be held in `pending` and is launched when the gap expires
// ---------------------------------------------------------------------------
module tick_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 2,
  parameter int CNT_W       = 8,
  parameter bit RETRIGGER   = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  output logic             level,
  output logic             busy,
  output logic             overrun,
  output logic [CNT_W-1:0] drop_count
);

  // Reload values are truncated to the counter width. With LOW_CYCLES == 0
  // the gap reload is never used.
  localparam logic [CNT_W-1:0] LP_HIGH_RELOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_LOW_RELOAD  = CNT_W'(LOW_CYCLES - 1);
  localparam bit               LP_HAS_GAP     = (LOW_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_pending;
  logic             w_pending_nxt;
  logic             r_level;
  logic             w_level_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_overrun;
  logic [CNT_W-1:0] r_drop_count;
  logic             w_drop;
  logic             w_cnt_tc;
  logic             w_drop_sat;

  assign w_cnt_tc   = (r_cnt == '0);
  assign w_drop_sat = &r_drop_count;

  // -------------------------------------------------------------------------
  // State, counter and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_level   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pending_nxt;
      r_level   <= w_level_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // Drop bookkeeping is kept apart from the FSM: a drop never disturbs
  // cnt, state or level.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overrun    <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_overrun <= w_drop;
      if (w_drop && !w_drop_sat) begin
        r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_pending;
    w_level_nxt   = r_level;
    w_busy_nxt    = r_busy;
    w_drop        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (tick) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = LP_HIGH_RELOAD;
          w_level_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end

      ST_HIGH: begin
        if (tick && RETRIGGER) begin
          // Restart beats expiry so the pulse always ends HIGH_CYCLES
          // after the most recent tick.
          w_cnt_nxt = LP_HIGH_RELOAD;
        end else begin
          if (tick) begin
            w_drop = 1'b1;
          end
          if (w_cnt_tc) begin
            w_level_nxt = 1'b0;
            if (LP_HAS_GAP) begin
              w_state_nxt = ST_GAP;
              w_cnt_nxt   = LP_LOW_RELOAD;
            end else begin
              w_state_nxt = ST_IDLE;
              w_busy_nxt  = 1'b0;
            end
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (w_cnt_tc) begin
          if (r_pending || tick) begin
            // A tick landing on the last gap cycle while one is already
            // held cannot be honoured as well.
            if (r_pending && tick) begin
              w_drop = 1'b1;
            end
            w_state_nxt   = ST_HIGH;
            w_cnt_nxt     = LP_HIGH_RELOAD;
            w_level_nxt   = 1'b1;
            w_pending_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (tick) begin
            if (r_pending) begin
              w_drop = 1'b1;
            end else begin
              w_pending_nxt = 1'b1;
            end
          end
        end
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_cnt_nxt     = '0;
        w_pending_nxt = 1'b0;
        w_level_nxt   = 1'b0;
        w_busy_nxt    = 1'b0;
      end
    endcase
  end

  assign level      = r_level;
  assign busy       = r_busy;
  assign overrun    = r_overrun;
  assign drop_count = r_drop_count;

endmodule
